// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - iterative shift-add unsigned multiplier for the EX stage (optional MUL_HI_EN adds result_hi)
module ex_mul_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         flush_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    output logic         stall_E,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
`ifdef MUL_HI_EN
    ,
    output logic [N-1:0] result_hi
`endif
);

`ifdef MUL_HI_EN
    localparam int AW = 2 * N;
`else
    localparam int AW = N;
`endif
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [AW-1:0]  r_mcand;
    logic [N-1:0]   r_mplier;
    logic [AW-1:0]  r_acc;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
`ifdef MUL_HI_EN
    logic [N-1:0]   r_result_hi;
`endif

    logic [AW-1:0]  w_acc_sum;
    logic [N-1:0]   w_mplier_shift;
    logic           w_last;
    logic           w_accept;

    assign w_accept       = (r_state == S_IDLE) && start && !flush_E;
    assign w_acc_sum      = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_shift = r_mplier >> 1;
    // Stop on the N-th iteration, or earlier once no multiplier bits remain.
    assign w_last         = (r_cnt == CW'(N - 1)) || (w_mplier_shift == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN: begin
                if (flush_E)     w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE);
        stall_E = w_accept || (r_state == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
`ifdef MUL_HI_EN
            r_result_hi <= '0;
`endif
        end else if (w_accept) begin
            r_mcand  <= AW'(opA_E);
            r_mplier <= opB_E;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN && !flush_E) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shift;
            r_acc    <= w_acc_sum;
            r_cnt    <= r_cnt + CW'(1);
            // Capture the final sum on entry to DONE so the outputs stay registered.
            if (w_last) begin
                r_result    <= w_acc_sum[N-1:0];
`ifdef MUL_HI_EN
                r_result_hi <= w_acc_sum[AW-1:N];
`endif
            end
        end
    end

    assign result    = r_result;
`ifdef MUL_HI_EN
    assign result_hi = r_result_hi;
`endif

endmodule

// File: tb/tb_ex_mul_seq.sv
// tb/tb_ex_mul_seq.sv - directed vector bench for ex_mul_seq
module tb_ex_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush_E = 1'b0;
    logic [63:0] opA_E = '0;
    logic [63:0] opB_E = '0;
    logic        stall_E;
    logic        busy;
    logic        done;
    logic [63:0] result;
`ifdef MUL_HI_EN
    logic [63:0] result_hi;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    ex_mul_seq #(.N(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .flush_E   (flush_E),
        .opA_E     (opA_E),
        .opB_E     (opB_E),
        .stall_E   (stall_E),
        .busy      (busy),
        .done      (done),
        .result    (result)
`ifdef MUL_HI_EN
        ,
        .result_hi (result_hi)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] lo;
        logic [63:0] hi;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents one operation; returns at the negedge of the done cycle (lat=-1 on timeout).
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, output int lat);
        @(negedge clk);
        start = 1'b1;
        opA_E = a;
        opB_E = b;
        #1;
        chk("stall_on_accept", {63'd0, stall_E}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int d0;
        logic [63:0] prev;

        vecs[0] = '{64'd7, 64'd6, 64'd42, 64'd0, 4};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2] = '{64'd123, 64'd0, 64'd0, 64'd0, 2};
        vecs[3] = '{64'd0, 64'd5, 64'd0, 64'd0, 4};
        vecs[4] = '{64'd3, 64'd1, 64'd3, 64'd0, 2};
        vecs[5] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd1, 34};
        vecs[6] = '{64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 65};
        vecs[7] = '{64'd12345, 64'd1000, 64'd12345000, 64'd0, 11};

        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_stall", {63'd0, stall_E}, 64'd0);
        chk("reset_result", result, 64'd0);
`ifdef MUL_HI_EN
        chk("reset_result_hi", result_hi, 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), result, vecs[i].lo);
`ifdef MUL_HI_EN
            chk($sformatf("v%0d_result_hi", i), result_hi, vecs[i].hi);
`endif
            chk($sformatf("v%0d_stall_done", i), {63'd0, stall_E}, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_idle_after", i), {63'd0, busy}, 64'd0);
        end

        // Flush in the third RUN cycle: abort, no done, result kept.
        prev = result;
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; opA_E = 64'd999; opB_E = 64'hFFFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush_E = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_E = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (20) @(negedge clk);
        chk("flush_no_done", 64'(done_seen - d0), 64'd0);
        chk("flush_result_kept", result, prev);

        // Start with flush in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1; flush_E = 1'b1; opA_E = 64'd5; opB_E = 64'd5;
        #1;
        chk("idle_flush_stall", {63'd0, stall_E}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        start = 1'b0; flush_E = 1'b0;

        // start re-presented with new operands during RUN is ignored.
        @(negedge clk);
        start = 1'b1; opA_E = 64'd7; opB_E = 64'd6;
        @(posedge clk); @(negedge clk);
        opA_E = 64'd100; opB_E = 64'd100;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("retrig_done_t3", {63'd0, done}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("retrig_done_t4", {63'd0, done}, 64'd1);
        chk("retrig_result", result, 64'd42);

        // Flush during DONE: done still pulses, then IDLE.
        run_op(64'd9, 64'd9, lat);
        chk("flush_done_latency", 64'(lat), 64'd5);
        flush_E = 1'b1;
        #1;
        chk("flush_done_pulse", {63'd0, done}, 64'd1);
        chk("flush_done_result", result, 64'd81);
        @(posedge clk); @(negedge clk);
        flush_E = 1'b0;
        chk("flush_done_idle", {63'd0, busy}, 64'd0);

        // Reset mid-RUN aborts; a fresh start afterwards works.
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; opA_E = 64'hFFFF_FFFF_FFFF_FFFF; opB_E = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("rst_mid_no_done", 64'(done_seen - d0), 64'd0);
        run_op(64'd7, 64'd6, lat);
        chk("rst_fresh_latency", 64'(lat), 64'd4);
        chk("rst_fresh_result", result, 64'd42);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
